// File: rtl/spu_controller.sv
// SPU control unit: fetches 16-bit instructions and sequences the datapath
// through a Moore FSM (fetch, decode, one execute state per opcode).
module spu_controller #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] i_addr,
  output logic            i_rd,
  input  logic [15:0]     i_data,
  output logic [7:0]      dm_addr,
  output logic            dm_rd,
  output logic            dm_wr,
  output logic [7:0]      rf_w_data,
  output logic            rf_s1,
  output logic            rf_s0,
  output logic [3:0]      rf_w_addr,
  output logic            rf_w_wr,
  output logic [3:0]      rf_rp_addr,
  output logic            rf_rp_rd,
  output logic [3:0]      rf_rq_addr,
  output logic            rf_rq_rd,
  output logic            alu_s1,
  output logic            alu_s0,
  input  logic            rf_rp_zero,
  output logic            halted
);

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_LOAD,
    S_STORE,
    S_ADD,
    S_SUB,
    S_LOADC,
    S_JMPZ,
    S_JMPZ_TAKE,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_LOADC = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_JMPZ  = 4'b0101;
  localparam logic [3:0] OP_HALT  = 4'b1111;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;

  logic [3:0]      op, ra, rb, rc;
  logic [7:0]      k;
  logic [PC_W-1:0] k_sext;

  assign op     = ir_q[15:12];
  assign ra     = ir_q[11:8];
  assign rb     = ir_q[7:4];
  assign rc     = ir_q[3:0];
  assign k      = ir_q[7:0];
  assign k_sext = {{(PC_W-8){k[7]}}, k};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_INIT: begin
        pc_d    = '0;
        state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d    = i_data;
        pc_d    = pc_q + PC_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (op)
          OP_LOAD:  state_d = S_LOAD;
          OP_STORE: state_d = S_STORE;
          OP_ADD:   state_d = S_ADD;
          OP_LOADC: state_d = S_LOADC;
          OP_SUB:   state_d = S_SUB;
          OP_JMPZ:  state_d = S_JMPZ;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_FETCH;
        endcase
      end
      S_LOAD, S_STORE, S_ADD, S_SUB, S_LOADC: state_d = S_FETCH;
      S_JMPZ: state_d = rf_rp_zero ? S_JMPZ_TAKE : S_FETCH;
      S_JMPZ_TAKE: begin
        // PC already points past the JMPZ, so back off one to get PC_of_instr + offset
        pc_d    = pc_q + k_sext - PC_W'(1);
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    i_addr     = '0;
    i_rd       = 1'b0;
    dm_addr    = '0;
    dm_rd      = 1'b0;
    dm_wr      = 1'b0;
    rf_w_data  = '0;
    rf_s1      = 1'b0;
    rf_s0      = 1'b0;
    rf_w_addr  = '0;
    rf_w_wr    = 1'b0;
    rf_rp_addr = '0;
    rf_rp_rd   = 1'b0;
    rf_rq_addr = '0;
    rf_rq_rd   = 1'b0;
    alu_s1     = 1'b0;
    alu_s0     = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_FETCH: begin
        i_addr = pc_q;
        i_rd   = 1'b1;
      end
      S_LOAD: begin
        dm_addr   = k;
        dm_rd     = 1'b1;
        rf_s0     = 1'b1;
        rf_w_addr = ra;
        rf_w_wr   = 1'b1;
      end
      S_STORE: begin
        dm_addr    = k;
        dm_wr      = 1'b1;
        rf_rp_addr = ra;
        rf_rp_rd   = 1'b1;
      end
      S_ADD, S_SUB: begin
        rf_rp_addr = rb;
        rf_rp_rd   = 1'b1;
        rf_rq_addr = rc;
        rf_rq_rd   = 1'b1;
        alu_s0     = (state_q == S_ADD);
        alu_s1     = (state_q == S_SUB);
        rf_w_addr  = ra;
        rf_w_wr    = 1'b1;
      end
      S_LOADC: begin
        rf_w_data = k;
        rf_s1     = 1'b1;
        rf_w_addr = ra;
        rf_w_wr   = 1'b1;
      end
      S_JMPZ: begin
        rf_rp_addr = ra;
        rf_rp_rd   = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spu_controller.sv
// Directed bench for spu_controller with a small behavioural datapath,
// instruction memory and data memory around it.
module tb_spu_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_addr;
  logic        i_rd;
  logic [15:0] i_data;
  logic [7:0]  dm_addr;
  logic        dm_rd, dm_wr;
  logic [7:0]  rf_w_data;
  logic        rf_s1, rf_s0;
  logic [3:0]  rf_w_addr;
  logic        rf_w_wr;
  logic [3:0]  rf_rp_addr;
  logic        rf_rp_rd;
  logic [3:0]  rf_rq_addr;
  logic        rf_rq_rd;
  logic        alu_s1, alu_s0;
  logic        rf_rp_zero;
  logic        halted;

  spu_controller #(.PC_W(16)) dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_rd(i_rd), .i_data(i_data),
    .dm_addr(dm_addr), .dm_rd(dm_rd), .dm_wr(dm_wr),
    .rf_w_data(rf_w_data), .rf_s1(rf_s1), .rf_s0(rf_s0),
    .rf_w_addr(rf_w_addr), .rf_w_wr(rf_w_wr),
    .rf_rp_addr(rf_rp_addr), .rf_rp_rd(rf_rp_rd),
    .rf_rq_addr(rf_rq_addr), .rf_rq_rd(rf_rq_rd),
    .alu_s1(alu_s1), .alu_s0(alu_s0),
    .rf_rp_zero(rf_rp_zero), .halted(halted)
  );

  always #5 clk = ~clk;

  // Environment: imem, dmem and a 16-bit register file datapath
  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  logic [15:0] rf   [16];
  logic [15:0] rp_data, rq_data, alu_y, wsrc;

  assign i_data     = imem[i_addr[7:0]];
  assign rp_data    = rf[rf_rp_addr];
  assign rq_data    = rf[rf_rq_addr];
  assign rf_rp_zero = (rp_data == 16'h0000);

  always_comb begin
    alu_y = rp_data;
    case ({alu_s1, alu_s0})
      2'b01:   alu_y = rp_data + rq_data;
      2'b10:   alu_y = rp_data - rq_data;
      default: alu_y = rp_data;
    endcase
    wsrc = alu_y;
    case ({rf_s1, rf_s0})
      2'b01:   wsrc = dmem[dm_addr];
      2'b10:   wsrc = {8'h00, rf_w_data};
      default: wsrc = alu_y;
    endcase
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= 16'h0000;
      for (int i = 0; i < 256; i++) dmem[i] <= 16'h0000;
      dmem[8'h10] <= 16'h1234;
    end else begin
      if (rf_w_wr) rf[rf_w_addr] <= wsrc;
      if (dm_wr) dmem[dm_addr] <= rp_data;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) imem[i] = 16'h6000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_fetch_at(input logic [15:0] a, input int budget);
    int n;
    n = 0;
    while (!(i_rd && i_addr == a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_reached", {31'd0, (i_rd && i_addr == a)}, 32'd1);
  endtask

  task automatic next_fetch(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!i_rd && n < 16);
  endtask

  logic [15:0] tr_wr, tr_ird, tr_dmrd, tr_dmwr, tr_rq;
  logic [5:0]  acc;
  logic        allh;
  int          ncyc;

  initial begin
    // Program 1: LOADC r1,5; LOADC r2,3; ADD r3,r1,r2; SUB r4,r2,r1; HALT
    fill_nop();
    imem[0] = 16'h3105;
    imem[1] = 16'h3203;
    imem[2] = 16'h2312;
    imem[3] = 16'h4421;
    imem[4] = 16'hF000;

    @(negedge clk);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_strobes", {26'd0, i_rd, dm_rd, dm_wr, rf_w_wr, rf_rp_rd, rf_rq_rd}, 32'd0);
    chk("rst_iaddr", {16'd0, i_addr}, 32'd0);

    do_reset();
    tr_wr = '0; tr_ird = '0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) @(negedge clk);
      tr_wr[c]  = rf_w_wr;
      tr_ird[c] = i_rd;
      if (c == 4) chk("fetch1_addr", {16'd0, i_addr}, 32'd1);
      if (c == 9) chk("add_ctl", {24'd0, alu_s1, alu_s0, rf_s1, rf_s0, rf_w_addr}, {24'd0, 8'b01_00_0011});
      if (c == 12) chk("sub_ctl", {24'd0, alu_s1, alu_s0, rf_s1, rf_s0, rf_w_addr}, {24'd0, 8'b10_00_0100});
      if (c == 15) chk("halt_enter", {31'd0, halted}, 32'd1);
    end
    chk("wr_pulses", {16'd0, tr_wr}, 32'h1248);
    chk("fetch_pulses", {16'd0, tr_ird}, 32'h2492);
    chk("r3_add", {16'd0, rf[3]}, 32'h0008);
    chk("r4_sub", {16'd0, rf[4]}, 32'hFFFE);

    acc = '0; allh = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      acc  = acc | {i_rd, dm_rd, dm_wr, rf_w_wr, rf_rp_rd, rf_rq_rd};
      allh = allh & halted;
    end
    chk("halt_quiet", {26'd0, acc}, 32'd0);
    chk("halt_hold", {31'd0, allh}, 32'd1);

    do_reset();
    chk("post_halt_rst", {31'd0, halted}, 32'd0);
    next_fetch(ncyc);
    chk("first_fetch_lat", ncyc, 32'd1);
    chk("first_fetch_addr", {16'd0, i_addr}, 32'd0);

    // Reset arriving during the ADD execute cycle
    do_reset();
    repeat (9) @(negedge clk);
    chk("add_exec_wr", {31'd0, rf_w_wr}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_strobes", {26'd0, i_rd, dm_rd, dm_wr, rf_w_wr, rf_rp_rd, rf_rq_rd}, 32'd0);
    chk("abort_sel", {24'd0, alu_s1, alu_s0, rf_s1, rf_s0, rf_w_addr}, 32'd0);

    // Program 2: LOAD r5,0x10; STORE r5,0x20; HALT
    fill_nop();
    imem[0] = 16'h0510;
    imem[1] = 16'h1520;
    imem[2] = 16'hF000;
    do_reset();
    tr_dmrd = '0; tr_dmwr = '0; tr_rq = '0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      tr_dmrd[c] = dm_rd;
      tr_dmwr[c] = dm_wr;
      tr_rq[c]   = rf_rq_rd;
      if (c == 3) chk("load_addr", {24'd0, dm_addr}, 32'h10);
      if (c == 6) chk("store_addr", {24'd0, dm_addr}, 32'h20);
      if (c == 9) chk("halt_pc2", {31'd0, halted}, 32'd1);
    end
    chk("dm_rd_pulse", {16'd0, tr_dmrd}, 32'h0008);
    chk("dm_wr_pulse", {16'd0, tr_dmwr}, 32'h0040);
    chk("rq_idle", {16'd0, tr_rq}, 32'd0);
    chk("r5_load", {16'd0, rf[5]}, 32'h1234);
    chk("dm20_store", {16'd0, dmem[8'h20]}, 32'h1234);

    // Program 3: NOPs then JMPZ r0,-2 at PC 6 with r0 == 0
    fill_nop();
    imem[6] = 16'h50FE;
    do_reset();
    wait_fetch_at(16'd6, 40);
    next_fetch(ncyc);
    chk("jmpz_taken_cyc", ncyc, 32'd4);
    chk("jmpz_taken_addr", {16'd0, i_addr}, 32'd4);

    // Program 4: r0 = 7 so the same JMPZ falls through
    fill_nop();
    imem[0] = 16'h3007;
    imem[6] = 16'h50FE;
    do_reset();
    wait_fetch_at(16'd6, 40);
    next_fetch(ncyc);
    chk("jmpz_nt_cyc", ncyc, 32'd3);
    chk("jmpz_nt_addr", {16'd0, i_addr}, 32'd7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
